// File: rtl/pool_event_unpacker_pkg.sv
// Shared types for the pooled-event path between a conv/pool layer and the
// next layer's event input.
//   pooled_word_t    : packed FIFO word {x, y, spikes, ts_end} at default sizes
//                      (x in the MSBs, ts_end in bit 0)
//   unpacker_state_t : FSM state of pool_event_unpacker
//   ch_bits_for()    : channel-index width, never narrower than one bit
package snn_interfaces_pkg;

   localparam int DEFAULT_COORD_BITS        = 8;
   localparam int DEFAULT_CHANNELS          = 4;
   localparam int DEFAULT_UNPACK_COUNT_BITS = 16;

   typedef struct packed {
      logic [DEFAULT_COORD_BITS-2:0] x;
      logic [DEFAULT_COORD_BITS-2:0] y;
      logic [DEFAULT_CHANNELS-1:0]   spikes;
      logic                          ts_end;
   } pooled_word_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_READ     = 2'd1,
      ST_SCAN     = 2'd2,
      ST_TS_PULSE = 2'd3
   } unpacker_state_t;

   function automatic int ch_bits_for(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/pool_event_unpacker_if.sv
// Bus bundle of pool_event_unpacker: FIFO read side plus event output side.
//   master : the unpacker (drives fifo_read_en and the event_* outputs)
//   slave  : the environment (FIFO + next layer)
//
// Handshake: event_valid/event_ready follow strict valid/ready rules. An
// event transfers on every clk edge where both are high; once valid is
// raised, valid and the payload (event_x, event_y, event_channel) hold
// unchanged until that transfer; valid never waits on ready.
// fifo_read_en is a one-cycle strobe; fifo_data is sampled the cycle after.
interface pool_event_unpacker_if
   import snn_interfaces_pkg::*;
#(
   parameter int COORD_BITS = DEFAULT_COORD_BITS,
   parameter int CHANNELS   = DEFAULT_CHANNELS
);
   localparam int IN_DATA_WIDTH = (COORD_BITS - 1) * 2 + CHANNELS + 1;
   localparam int CH_BITS       = ch_bits_for(CHANNELS);

   logic                     fifo_empty;
   logic                     fifo_read_en;
   logic [IN_DATA_WIDTH-1:0] fifo_data;
   logic                     event_valid;
   logic                     event_ready;
   logic [COORD_BITS-1:0]    event_x;
   logic [COORD_BITS-1:0]    event_y;
   logic [CH_BITS-1:0]       event_channel;

   modport master (
      input  fifo_empty, fifo_data, event_ready,
      output fifo_read_en, event_valid, event_x, event_y, event_channel
   );

   modport slave (
      output fifo_empty, fifo_data, event_ready,
      input  fifo_read_en, event_valid, event_x, event_y, event_channel
   );

endinterface

// File: rtl/pool_event_unpacker_lowest_set_bit_encoder.sv
// Combinational lowest-set-bit finder.
//   mask_i   : CHANNELS-wide spike mask
//   index_o  : index of the lowest set bit (0 when the mask is empty)
//   onehot_o : one-hot of that bit, used to clear it from the mask
module lowest_set_bit_encoder #(
   parameter int CHANNELS = 4,
   parameter int CH_BITS  = 2
) (
   input  logic [CHANNELS-1:0] mask_i,
   output logic [CH_BITS-1:0]  index_o,
   output logic [CHANNELS-1:0] onehot_o
);

   always_comb begin
      // Two's-complement trick isolates the lowest set bit.
      onehot_o = mask_i & (~mask_i + CHANNELS'(1));
      index_o  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (onehot_o[i]) index_o = CH_BITS'(i);
      end
   end

endmodule

// File: rtl/pool_event_unpacker.sv
// Drains the pooled-output FIFO one word at a time and emits one spike event
// per set channel bit (ascending channel order), then a one-cycle
// end-of-timestep pulse when the word carries the marker.
//   clk, rst_n     : clock, synchronous active-low reset
//   enable         : permits new FIFO reads (an in-progress word always completes)
//   clear          : synchronous flush, same effect as reset, highest priority
//   bus            : FIFO read side and event valid/ready side (master modport)
//   timestep_out   : one-cycle end-of-timestep pulse
//   busy           : high whenever the FSM is not in IDLE
//   events_emitted : saturating count of accepted events
//   dbg_state_o    : current FSM state
module pool_event_unpacker
   import snn_interfaces_pkg::*;
#(
   parameter int COORD_BITS = DEFAULT_COORD_BITS,
   parameter int CHANNELS   = DEFAULT_CHANNELS,
   parameter int COUNT_BITS = DEFAULT_UNPACK_COUNT_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  clear,
   pool_event_unpacker_if.master bus,
   output logic                  timestep_out,
   output logic                  busy,
   output logic [COUNT_BITS-1:0] events_emitted,
   output unpacker_state_t       dbg_state_o
);

   localparam int PC            = COORD_BITS - 1;
   localparam int IN_DATA_WIDTH = 2 * PC + CHANNELS + 1;
   localparam int CH_BITS       = ch_bits_for(CHANNELS);

   unpacker_state_t       state_q;
   logic                  read_en_q;
   logic                  read_wait_q;
   logic                  valid_q;
   logic                  ts_pulse_q;
   logic                  busy_q;
   logic [PC-1:0]         x_q;
   logic [PC-1:0]         y_q;
   logic [CHANNELS-1:0]   mask_q;
   logic                  ts_end_q;
   logic [CH_BITS-1:0]    ch_q;
   logic [COUNT_BITS-1:0] cnt_q;

   logic [PC-1:0]       word_x;
   logic [PC-1:0]       word_y;
   logic [CHANNELS-1:0] word_spikes;
   logic                word_ts;

   assign word_x      = bus.fifo_data[IN_DATA_WIDTH-1 -: PC];
   assign word_y      = bus.fifo_data[IN_DATA_WIDTH-1-PC -: PC];
   assign word_spikes = bus.fifo_data[CHANNELS:1];
   assign word_ts     = bus.fifo_data[0];

   // mask_q holds the channels still pending *after* the one in ch_q, so the
   // encoder always yields the next channel to load. In READ it looks at the
   // incoming word instead, picking the first channel directly.
   logic [CHANNELS-1:0] enc_src;
   logic [CH_BITS-1:0]  enc_index;
   logic [CHANNELS-1:0] enc_onehot;

   assign enc_src = (state_q == ST_READ) ? word_spikes : mask_q;

   lowest_set_bit_encoder #(
      .CHANNELS (CHANNELS),
      .CH_BITS  (CH_BITS)
   ) u_lsb (
      .mask_i   (enc_src),
      .index_o  (enc_index),
      .onehot_o (enc_onehot)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state_q     <= ST_IDLE;
         read_en_q   <= 1'b0;
         read_wait_q <= 1'b0;
         valid_q     <= 1'b0;
         ts_pulse_q  <= 1'b0;
         busy_q      <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         mask_q      <= '0;
         ts_end_q    <= 1'b0;
         ch_q        <= '0;
         cnt_q       <= '0;
      end else begin
         read_en_q  <= 1'b0;
         ts_pulse_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable && !bus.fifo_empty) begin
                  read_en_q   <= 1'b1;
                  read_wait_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= ST_READ;
               end
            end
            ST_READ: begin
               // The strobe is registered, so the first READ cycle is the
               // strobe cycle itself; the word is on fifo_data one cycle later.
               if (read_wait_q) begin
                  read_wait_q <= 1'b0;
               end else begin
                  x_q      <= word_x;
                  y_q      <= word_y;
                  ts_end_q <= word_ts;
                  mask_q   <= word_spikes & ~enc_onehot;
                  ch_q     <= enc_index;
                  if (word_spikes != '0) begin
                     valid_q <= 1'b1;
                     state_q <= ST_SCAN;
                  end else if (word_ts) begin
                     ts_pulse_q <= 1'b1;
                     state_q    <= ST_TS_PULSE;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_SCAN: begin
               if (bus.event_ready) begin
                  if (cnt_q != {COUNT_BITS{1'b1}}) cnt_q <= cnt_q + COUNT_BITS'(1);
                  if (mask_q == '0) begin
                     valid_q <= 1'b0;
                     if (ts_end_q) begin
                        ts_pulse_q <= 1'b1;
                        state_q    <= ST_TS_PULSE;
                     end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     ch_q   <= enc_index;
                     mask_q <= mask_q & ~enc_onehot;
                  end
               end
            end
            ST_TS_PULSE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.fifo_read_en  = read_en_q;
   assign bus.event_valid   = valid_q;
   assign bus.event_x       = {1'b0, x_q};
   assign bus.event_y       = {1'b0, y_q};
   assign bus.event_channel = ch_q;
   assign timestep_out      = ts_pulse_q;
   assign busy              = busy_q;
   assign events_emitted    = cnt_q;
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_pool_event_unpacker.sv
// Directed bench for pool_event_unpacker (COORD_BITS=8, CHANNELS=4).
// A FIFO model feeds words; each popped word is expanded into its expected
// event list plus an optional timestep marker, and every cycle the DUT
// outputs are compared against that list.
module tb_pool_event_unpacker;
   import snn_interfaces_pkg::*;

   localparam int COORD_BITS = 8;
   localparam int CHANNELS   = 4;
   localparam int COUNT_BITS = 16;
   localparam int EW         = 1 + 2 * COORD_BITS + 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  enable;
   logic                  clear;
   logic                  timestep_out;
   logic                  busy;
   logic [COUNT_BITS-1:0] events_emitted;
   unpacker_state_t       dbg_state;

   pool_event_unpacker_if #(.COORD_BITS(COORD_BITS), .CHANNELS(CHANNELS)) bus ();

   pool_event_unpacker #(
      .COORD_BITS (COORD_BITS),
      .CHANNELS   (CHANNELS),
      .COUNT_BITS (COUNT_BITS)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .clear          (clear),
      .bus            (bus),
      .timestep_out   (timestep_out),
      .busy           (busy),
      .events_emitted (events_emitted),
      .dbg_state_o    (dbg_state)
   );

   always #5 clk = ~clk;

   // FIFO model and scoreboard state
   pooled_word_t    fifo_mem [32];
   int              wr_ptr, rd_ptr;
   logic [EW-1:0]   exp_q [$];
   logic [EW-2:0]   obs_q [$];
   int              obs_cyc_q [$];
   logic [COUNT_BITS-1:0] exp_cnt;
   int              n_vec, n_fail, cyc;
   int              strobe_cnt, ts_cnt, strobe_cyc, exp_first, last_acc_cyc, last_ts_cyc;
   bit              first_pending;
   logic            prev_valid, prev_ready, prev_ts;
   logic [EW-2:0]   prev_payload;
   int              s_base, t_base;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic pooled_word_t mk(input int x, input int y, input logic [3:0] sp, input logic ts);
      pooled_word_t w;
      w.x = 7'(x); w.y = 7'(y); w.spikes = sp; w.ts_end = ts;
      return w;
   endfunction

   task automatic push(input pooled_word_t w);
      fifo_mem[wr_ptr] = w;
      wr_ptr++;
      bus.fifo_empty = (rd_ptr == wr_ptr);
   endtask

   // One clock: compare at the negedge, then FIFO response just after posedge.
   task automatic tick();
      logic [EW-1:0] ent;
      logic [EW-2:0] pay;
      logic          do_pop;
      pooled_word_t  w;
      @(negedge clk);
      cyc++;
      do_pop = 1'b0;
      pay = {bus.event_x, bus.event_y, bus.event_channel};
      if (!rst_n || clear) begin
         exp_q.delete();
         first_pending = 0;
         exp_cnt       = '0;
         prev_valid    = 1'b0;
         prev_ts       = 1'b0;
      end else begin
         check("events_emitted", 32'(events_emitted), 32'(exp_cnt));
         if (bus.event_valid || timestep_out || bus.fifo_read_en)
            check("busy_while_active", 32'(busy), 32'd1);
         if (prev_ts) check("busy_after_ts", 32'(busy), 32'd0);
         if (bus.fifo_read_en) begin
            check("read_while_empty", 32'(bus.fifo_empty), 32'd0);
            strobe_cnt++;
            strobe_cyc = cyc;
            do_pop = 1'b1;
         end
         if ((bus.event_valid || timestep_out) && first_pending) begin
            check("first_out_latency", 32'(cyc), 32'(exp_first));
            first_pending = 0;
         end
         if (prev_valid && !prev_ready) begin
            check("valid_hold", 32'(bus.event_valid), 32'd1);
            check("payload_hold", 32'(pay), 32'(prev_payload));
         end
         if (bus.event_valid && bus.event_ready) begin
            ent = (exp_q.size() > 0) ? exp_q.pop_front() : {EW{1'b1}};
            check("event", 32'({1'b0, pay}), 32'(ent));
            if (exp_cnt != 16'hFFFF) exp_cnt++;
            obs_q.push_back(pay);
            obs_cyc_q.push_back(cyc);
            last_acc_cyc = cyc;
         end
         if (timestep_out) begin
            ent = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("ts_marker", 32'(ent), 32'({1'b1, 18'h0}));
            check("ts_one_cycle", 32'(prev_ts), 32'd0);
            ts_cnt++;
            last_ts_cyc = cyc;
         end
         prev_valid   = bus.event_valid;
         prev_ready   = bus.event_ready;
         prev_ts      = timestep_out;
         prev_payload = pay;
      end
      @(posedge clk);
      #1;
      if (do_pop) begin
         w = fifo_mem[rd_ptr];
         rd_ptr++;
         bus.fifo_data  = w;
         bus.fifo_empty = (rd_ptr == wr_ptr);
         for (int c = 0; c < CHANNELS; c++)
            if (w.spikes[c]) exp_q.push_back({1'b0, 8'(w.x), 8'(w.y), 2'(c)});
         if (w.ts_end) exp_q.push_back({1'b1, 18'h0});
         if (w.spikes != 4'b0 || w.ts_end) begin
            first_pending = 1;
            exp_first     = strobe_cyc + 2;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      n_vec = 0; n_fail = 0; cyc = 0; wr_ptr = 0; rd_ptr = 0;
      strobe_cnt = 0; ts_cnt = 0; strobe_cyc = 0; exp_first = 0;
      last_acc_cyc = 0; last_ts_cyc = 0; first_pending = 0;
      prev_valid = 0; prev_ready = 0; prev_ts = 0; prev_payload = '0;
      exp_cnt = '0;
      rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
      bus.event_ready = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_data = '0;
      run(3);

      // Reset state
      check("rst_read_en", 32'(bus.fifo_read_en), 32'd0);
      check("rst_valid", 32'(bus.event_valid), 32'd0);
      check("rst_ts", 32'(timestep_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_xyc", 32'({bus.event_x, bus.event_y, bus.event_channel}), 32'd0);
      check("rst_count", 32'(events_emitted), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      run(2);

      // 1: two events, ready high
      enable = 1'b1; bus.event_ready = 1'b1;
      obs_q.delete(); obs_cyc_q.delete(); t_base = ts_cnt;
      push(mk(5, 3, 4'b1010, 1'b0));
      run(10);
      check("t1_n_events", 32'(obs_q.size()), 32'd2);
      if (obs_q.size() == 2) begin
         check("t1_ev0", 32'(obs_q[0]), 32'({8'd5, 8'd3, 2'd1}));
         check("t1_ev1", 32'(obs_q[1]), 32'({8'd5, 8'd3, 2'd3}));
         check("t1_back_to_back", 32'(obs_cyc_q[1]), 32'(obs_cyc_q[0] + 1));
      end
      check("t1_no_ts", 32'(ts_cnt), 32'(t_base));
      check("t1_count", 32'(events_emitted), 32'd2);

      // 2: marker-only word
      obs_q.delete(); t_base = ts_cnt;
      push(mk(0, 0, 4'b0000, 1'b1));
      run(8);
      check("t2_ts_count", 32'(ts_cnt), 32'(t_base + 1));
      check("t2_ts_latency", 32'(last_ts_cyc), 32'(strobe_cyc + 2));
      check("t2_no_events", 32'(obs_q.size()), 32'd0);
      check("t2_busy_low", 32'(busy), 32'd0);

      // 3: full mask, ready toggling, marker after last accept
      obs_q.delete(); t_base = ts_cnt;
      push(mk(127, 127, 4'b1111, 1'b1));
      for (int i = 0; i < 16; i++) begin
         bus.event_ready = (i % 2 == 0);
         tick();
      end
      bus.event_ready = 1'b1;
      run(2);
      check("t3_n_events", 32'(obs_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < obs_q.size(); i++)
         check("t3_ev", 32'(obs_q[i]), 32'({8'd127, 8'd127, 2'(i)}));
      check("t3_ts_count", 32'(ts_cnt), 32'(t_base + 1));
      check("t3_ts_after_accept", 32'(last_ts_cyc), 32'(last_acc_cyc + 1));
      check("t3_count", 32'(events_emitted), 32'd6);

      // 4: enable dropped after the first strobe
      enable = 1'b0;
      push(mk(1, 1, 4'b0001, 1'b0));
      push(mk(2, 2, 4'b0010, 1'b0));
      push(mk(3, 3, 4'b0100, 1'b1));
      run(3);
      obs_q.delete(); s_base = strobe_cnt; t_base = ts_cnt;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      run(12);
      check("t4_one_strobe", 32'(strobe_cnt), 32'(s_base + 1));
      check("t4_one_event", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0) check("t4_ev0", 32'(obs_q[0]), 32'({8'd1, 8'd1, 2'd0}));
      enable = 1'b1;
      run(16);
      check("t4_all_strobes", 32'(strobe_cnt), 32'(s_base + 3));
      check("t4_three_events", 32'(obs_q.size()), 32'd3);
      if (obs_q.size() == 3) check("t4_ev2", 32'(obs_q[2]), 32'({8'd3, 8'd3, 2'd2}));
      check("t4_ts_count", 32'(ts_cnt), 32'(t_base + 1));
      check("t4_drained", 32'(exp_q.size()), 32'd0);

      // 5: clear mid-scan with two channels pending
      obs_q.delete(); t_base = ts_cnt;
      bus.event_ready = 1'b0;
      push(mk(9, 2, 4'b1100, 1'b1));
      run(6);
      check("t5_valid_before_clear", 32'(bus.event_valid), 32'd1);
      clear = 1'b1; bus.event_ready = 1'b1;
      tick();
      check("t5_state", 32'(dbg_state), 32'(ST_IDLE));
      check("t5_valid", 32'(bus.event_valid), 32'd0);
      check("t5_count", 32'(events_emitted), 32'd0);
      clear = 1'b0;
      run(8);
      check("t5_no_events", 32'(obs_q.size()), 32'd0);
      check("t5_no_ts", 32'(ts_cnt), 32'(t_base));

      // 6: counter saturation
      force dut.cnt_q = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      tick();
      release dut.cnt_q;
      obs_q.delete();
      push(mk(4, 6, 4'b0001, 1'b0));
      run(8);
      check("t6_one_event", 32'(obs_q.size()), 32'd1);
      check("t6_saturated", 32'(events_emitted), 32'hFFFF);
      check("final_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
